// File: rtl/sync_splitter_n.sv
// Clocked N-way fork: one upstream valid/ready token is held in a single register
// stage and delivered to every selected downstream channel, each completing independently.
module sync_splitter_n #(
  parameter int NUM_OUT     = 3,
  parameter int DATA_WIDTHI = 32,
  parameter int MODE        = 0,
  parameter int SLICE_WIDTH = 8,
  parameter int MASK_EN     = 1,
  parameter int CNT_WIDTH   = 16,
  localparam int OW         = (MODE == 1) ? SLICE_WIDTH : DATA_WIDTHI
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_drive,
  output logic                     o_free,
  input  logic [DATA_WIDTHI-1:0]   i_data,
  input  logic [NUM_OUT-1:0]       i_mask,
  output logic [NUM_OUT-1:0]       o_driveNext,
  input  logic [NUM_OUT-1:0]       i_freeNext,
  output logic [NUM_OUT*OW-1:0]    o_data,
  output logic                     o_busy,
  output logic [CNT_WIDTH-1:0]     o_xfer_cnt,
  output logic [CNT_WIDTH-1:0]     o_drop_cnt
);

  logic                   full_q;
  logic [NUM_OUT-1:0]     pend_q;
  logic [DATA_WIDTHI-1:0] data_q;
  logic [CNT_WIDTH-1:0]   xfer_q;
  logic [CNT_WIDTH-1:0]   drop_q;

  logic [NUM_OUT-1:0]     emask;
  logic [NUM_OUT-1:0]     drive;
  logic [NUM_OUT-1:0]     done;
  logic                   last;
  logic                   accept;
  logic                   mask_zero;

  // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    emask     = (MASK_EN != 0) ? i_mask : '1;
    drive     = rst ? '0 : (pend_q & {NUM_OUT{full_q}});
    done      = drive & i_freeNext;
    // The token retires once nothing remains pending after this cycle's completions.
    last      = full_q & ((pend_q & ~done) == '0);
    o_free    = ~rst & (~full_q | last);
    accept    = i_drive & o_free;
    mask_zero = (emask == '0);
  end

  // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      pend_q <= '0;
      data_q <= '0;
      xfer_q <= '0;
      drop_q <= '0;
    end else begin
      if (accept && !mask_zero) begin
        // Also covers reload on the retiring cycle, so back-to-back tokens need no bubble.
        full_q <= 1'b1;
        pend_q <= emask;
        data_q <= i_data;
      end else if (last) begin
        full_q <= 1'b0;
        pend_q <= '0;
      end else begin
        pend_q <= pend_q & ~done;
      end

      if (last && (xfer_q != '1)) begin
        xfer_q <= xfer_q + CNT_WIDTH'(1);
      end
      if (accept && mask_zero && (drop_q != '1)) begin
        drop_q <= drop_q + CNT_WIDTH'(1);
      end
    end
  end

  // Split mode hands out slices MSB-first: channel 0 gets the top slice.
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_ch
    if (MODE == 1) begin : g_split
      assign o_data[k*OW +: OW] = data_q[DATA_WIDTHI-1-k*SLICE_WIDTH -: SLICE_WIDTH];
    end else begin : g_copy
      assign o_data[k*OW +: OW] = data_q;
    end
  end

  // Low data bits in split mode and the mask with masking disabled are legitimately unused.
  logic unused_bits;
  assign unused_bits = ^{i_mask, data_q};

  assign o_driveNext = drive;
  assign o_busy      = full_q;
  assign o_xfer_cnt  = xfer_q;
  assign o_drop_cnt  = drop_q;

endmodule

// File: tb/tb_sync_splitter_n.sv
// Bench for sync_splitter_n: a copy-mode masked instance and a split-mode unmasked
// instance share stimulus and are compared every cycle against a token-level model.
module tb_sync_splitter_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        drv;
  logic [31:0] din;
  logic [2:0]  mask;
  logic [2:0]  rdy;

  logic        a_free, a_busy;
  logic [2:0]  a_drv;
  logic [95:0] a_data;
  logic [3:0]  a_xfer, a_drop;

  logic        b_free, b_busy;
  logic [2:0]  b_drv;
  logic [23:0] b_data;
  logic [15:0] b_xfer, b_drop;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sync_splitter_n #(
    .NUM_OUT(3), .DATA_WIDTHI(32), .MODE(0), .SLICE_WIDTH(8), .MASK_EN(1), .CNT_WIDTH(4)
  ) u_copy (
    .clk(clk), .rst(rst), .i_drive(drv), .o_free(a_free), .i_data(din), .i_mask(mask),
    .o_driveNext(a_drv), .i_freeNext(rdy), .o_data(a_data), .o_busy(a_busy),
    .o_xfer_cnt(a_xfer), .o_drop_cnt(a_drop)
  );

  sync_splitter_n #(
    .NUM_OUT(3), .DATA_WIDTHI(24), .MODE(1), .SLICE_WIDTH(8), .MASK_EN(0), .CNT_WIDTH(16)
  ) u_split (
    .clk(clk), .rst(rst), .i_drive(drv), .o_free(b_free), .i_data(din[23:0]), .i_mask(mask),
    .o_driveNext(b_drv), .i_freeNext(rdy), .o_data(b_data), .o_busy(b_busy),
    .o_xfer_cnt(b_xfer), .o_drop_cnt(b_drop)
  );

  // Token-level model: a held token and the set of channels that still owe a delivery.
  typedef struct {
    bit        full;
    bit [2:0]  rem;
    bit [31:0] data;
    int        xfer;
    int        drop;
  } mdl_t;

  mdl_t ma, mb;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_free(mdl_t s, bit r, bit [2:0] ready);
    if (r) return 1'b0;
    if (!s.full) return 1'b1;
    return (s.rem & ~ready) == 3'b000;
  endfunction

  function automatic mdl_t m_next(mdl_t s, bit r, bit d, bit [31:0] data, bit [2:0] m,
                                  bit [2:0] ready, int cmax);
    mdl_t n;
    bit   acc;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    n   = s;
    acc = d && m_free(s, r, ready);
    if (s.full) begin
      n.rem = s.rem & ~ready;
      if (n.rem == 3'b000) begin
        n.full = 1'b0;
        n.xfer = (s.xfer < cmax) ? s.xfer + 1 : cmax;
      end
    end
    if (acc) begin
      if (m == 3'b000) begin
        n.drop = (s.drop < cmax) ? s.drop + 1 : cmax;
      end else begin
        n.full = 1'b1;
        n.rem  = m;
        n.data = data;
      end
    end
    return n;
  endfunction

  // Inputs are already driven (after a falling edge); check, then advance one clock.
  task automatic step();
    #1;
    check("a_free",  a_free, m_free(ma, rst, rdy));
    check("a_drive", a_drv,  (ma.full && !rst) ? ma.rem : 3'b000);
    check("a_busy",  a_busy, ma.full);
    check("a_xfer",  a_xfer, ma.xfer);
    check("a_drop",  a_drop, ma.drop);
    check("b_free",  b_free, m_free(mb, rst, rdy));
    check("b_drive", b_drv,  (mb.full && !rst) ? mb.rem : 3'b000);
    check("b_busy",  b_busy, mb.full);
    check("b_xfer",  b_xfer, mb.xfer);
    check("b_drop",  b_drop, mb.drop);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("a_data%0d", k), a_data[k*32 +: 32], ma.data);
      check($sformatf("b_data%0d", k), b_data[k*8 +: 8], (mb.data >> (16 - 8 * k)) & 32'hFF);
    end
    @(posedge clk);
    ma = m_next(ma, rst, drv, din, mask, rdy, 15);
    mb = m_next(mb, rst, drv, {8'h00, din[23:0]}, 3'b111, rdy, 65535);
    @(negedge clk);
  endtask

  task automatic cyc(bit r, bit d, logic [31:0] data, logic [2:0] m, logic [2:0] ready);
    rst  = r;
    drv  = d;
    din  = data;
    mask = m;
    rdy  = ready;
    step();
  endtask

  initial begin
    rst = 1'b1; drv = 1'b0; din = '0; mask = '0; rdy = '0;
    ma = '{default: 0};
    mb = '{default: 0};
    @(posedge clk);
    @(negedge clk);
    cyc(1, 0, 0, 3'b000, 3'b000);

    // Back-to-back tokens with every consumer ready.
    cyc(0, 1, 32'h11, 3'b111, 3'b111);
    cyc(0, 1, 32'h22, 3'b111, 3'b111);
    cyc(0, 1, 32'h33, 3'b111, 3'b111);
    cyc(0, 0, 32'h0,  3'b111, 3'b111);
    check("plan_a_xfer3", a_xfer, 3);
    check("plan_b_xfer3", b_xfer, 3);

    // Split mapping, held while consumers stall.
    cyc(0, 1, 32'h00AABBCC, 3'b111, 3'b000);
    check("split_ch0", b_data[7:0],   8'hAA);
    check("split_ch1", b_data[15:8],  8'hBB);
    check("split_ch2", b_data[23:16], 8'hCC);
    cyc(0, 0, 0, 3'b000, 3'b111);

    // Staggered completion with token B waiting upstream.
    cyc(0, 1, 32'hA, 3'b111, 3'b000);
    cyc(0, 1, 32'hB, 3'b111, 3'b001);
    check("stag_pend110", a_drv, 3'b110);
    cyc(0, 1, 32'hB, 3'b111, 3'b100);
    check("stag_pend010", a_drv, 3'b010);
    cyc(0, 1, 32'hB, 3'b111, 3'b010);
    check("stag_b_drive", a_drv, 3'b111);
    check("stag_b_data",  a_data[31:0], 32'hB);
    cyc(0, 0, 0, 3'b000, 3'b111);

    // Zero mask drops on the masked instance but delivers on the unmasked one.
    cyc(0, 1, 32'h55, 3'b000, 3'b111);
    check("drop_cnt1",   a_drop, 1);
    check("drop_idle",   a_busy, 0);
    check("nomask_busy", b_busy, 1);
    cyc(0, 0, 0, 3'b000, 3'b111);

    // Single-channel mask ignores ready on unselected channels.
    cyc(0, 1, 32'h66, 3'b010, 3'b000);
    check("mask010_a", a_drv, 3'b010);
    cyc(0, 0, 0, 3'b000, 3'b101);
    check("mask010_b", a_drv, 3'b010);
    cyc(0, 0, 0, 3'b000, 3'b010);
    check("mask010_done", a_busy, 0);

    // Reset while a token is partially pending.
    cyc(0, 1, 32'h77, 3'b101, 3'b000);
    check("rst_pend101", a_drv, 3'b101);
    cyc(1, 0, 0, 3'b000, 3'b000);
    check("rst_drive", a_drv,  3'b000);
    check("rst_busy",  a_busy, 0);
    check("rst_xfer",  a_xfer, 0);
    check("rst_drop",  a_drop, 0);
    cyc(0, 0, 0, 3'b000, 3'b000);

    // Saturation of the narrow counter.
    for (int i = 0; i < 20; i++) cyc(0, 1, i, 3'b111, 3'b111);
    cyc(0, 0, 0, 3'b000, 3'b111);
    check("sat_a_xfer", a_xfer, 4'hF);
    check("sat_b_xfer", b_xfer, 20);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom,
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
